// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder among NREQ requesters,
// with a two-beat ADD64 lock and a single registered response slot.
module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    output logic              add_cin,
    input  logic [31:0]       add_sum,
    input  logic              add_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_ovf
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LO  = 2'b10;
    localparam logic [1:0] OP_HI  = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_lock_id;
    logic [IDW-1:0]  w_lock_nxt;
    logic            r_saved_c;
    logic            w_saved_nxt;

    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [31:0]     r_rsp_sum;
    logic            r_rsp_cout;
    logic            r_rsp_ovf;

    logic            w_gnt_any;
    logic [IDW-1:0]  w_gnt_idx;
    logic [NREQ-1:0] w_gnt_vec;
    logic [1:0]      w_op;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic            w_slot_free;
    logic            w_accept;
    logic            w_ovf;
    logic [IDW-1:0]  w_ptr_nxt;

    // Downward search so the closest requester at/after rr_ptr wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        if (r_state == S_LOCKED) begin
            w_gnt_any = req_valid[r_lock_id];
            w_gnt_idx = r_lock_id;
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
                end
            end
        end
    end

    assign w_op = req_op[2*w_gnt_idx +: 2];
    assign w_a  = req_a[32*w_gnt_idx +: 32];
    assign w_b  = req_b[32*w_gnt_idx +: 32];

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (w_gnt_any) begin
            unique case (w_op)
                OP_ADD: begin
                    add_a = w_a;
                    add_b = w_b;
                end
                OP_SUB: begin
                    add_a   = w_a;
                    add_b   = ~w_b;
                    add_cin = 1'b1;
                end
                OP_LO: begin
                    add_a = w_a;
                    add_b = w_b;
                end
                OP_HI: begin
                    add_a   = w_a;
                    add_b   = w_b;
                    add_cin = (r_state == S_LOCKED) &&
                              (w_gnt_idx == r_lock_id) &&
                              r_saved_c;
                end
                default: ;
            endcase
        end
    end

    assign w_ovf = (add_a[31] == add_b[31]) &
                   (add_sum[31] != add_a[31]);

    assign w_slot_free = ~r_rsp_valid | rsp_ready;
    assign w_gnt_vec   = NREQ'(w_gnt_any) << w_gnt_idx;
    assign req_ready   = w_gnt_vec & {NREQ{w_slot_free}};
    assign w_accept    = w_gnt_any & w_slot_free;
    assign w_ptr_nxt   = (int'(w_gnt_idx) == NREQ - 1) ?
                         '0 : w_gnt_idx + 1'b1;

    // Any non-LO beat from the lock owner ends the lock.
    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved_c;
        w_lock_nxt  = r_lock_id;
        if (w_accept) begin
            if (w_op == OP_LO) begin
                w_state_nxt = S_LOCKED;
                w_saved_nxt = add_cout;
                w_lock_nxt  = w_gnt_idx;
            end else if (r_state == S_LOCKED) begin
                w_state_nxt = S_IDLE;
                w_saved_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_saved_c <= 1'b0;
            r_lock_id <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_saved_c <= w_saved_nxt;
            r_lock_id <= w_lock_nxt;
            if (w_accept) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gnt_idx;
            r_rsp_sum   <= add_sum;
            r_rsp_cout  <= add_cout;
            r_rsp_ovf   <= w_ovf;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_ovf   = r_rsp_ovf;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: vector table, scoreboard monitor,
// and hand sequences for round robin, lock, backpressure and reset.
module tb_adder_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_op;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic              add_cin;
    logic [31:0]       add_sum;
    logic              add_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_sum;
    logic              rsp_cout;
    logic              rsp_ovf;

    adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared bit_32_add instance.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} +
                                 {32'd0, add_cin};

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    exp_t sb[$];
    vec_t vt[13];
    int   checks = 0;
    int   errors = 0;

    logic m_locked = 1'b0;
    int   m_lock   = 0;
    logic m_saved  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accept, pop when the response drains.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [32:0] s;
        logic        cin;
        if (!rst_n) begin
            sb.delete();
            m_locked = 1'b0;
            m_lock   = 0;
            m_saved  = 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_extra: got id %0d sum %h, expected none",
                             rsp_id, rsp_sum);
                end else begin
                    e = sb.pop_front();
                    chk("sb_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_sum", rsp_sum, e.sum);
                    chk("sb_cout", 32'(rsp_cout), 32'(e.cout));
                    chk("sb_ovf", 32'(rsp_ovf), 32'(e.ovf));
                end
            end
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    op  = req_op[2*i +: 2];
                    a   = req_a[32*i +: 32];
                    b   = req_b[32*i +: 32];
                    cin = (op == 2'b11) && m_locked && (m_lock == i) && m_saved;
                    e.id = i;
                    if (op == 2'b01) begin
                        s      = {1'b0, a} - {1'b0, b};
                        e.cout = (a >= b);
                        e.ovf  = (a[31] != b[31]) && (s[31] != a[31]);
                    end else begin
                        s      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                        e.cout = s[32];
                        e.ovf  = (a[31] == b[31]) && (s[31] != a[31]);
                    end
                    e.sum = s[31:0];
                    sb.push_back(e);
                    if (op == 2'b10) begin
                        m_locked = 1'b1;
                        m_lock   = i;
                        m_saved  = e.cout;
                    end else begin
                        m_locked = 1'b0;
                        m_saved  = 1'b0;
                    end
                end
            end
        end
    end

    task automatic set_req(input int id, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[2*id +: 2] = op;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
    endtask

    // Presents one request and returns at posedge+1 after its accept.
    task automatic do_req(input int id, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: req %0d got no ready, expected ready", id);
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    initial begin
        vt[0]  = '{0, 2'b00, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0};
        vt[1]  = '{0, 2'b00, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1};
        vt[2]  = '{1, 2'b01, 32'h5, 32'h7, 32'hFFFFFFFE, 1'b0, 1'b0};
        vt[3]  = '{1, 2'b01, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vt[4]  = '{3, 2'b00, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0};
        vt[5]  = '{2, 2'b01, 32'h7, 32'h7, 32'h0, 1'b1, 1'b0};
        vt[6]  = '{3, 2'b00, 32'h80000000, 32'h80000000, 32'h0, 1'b1, 1'b1};
        vt[7]  = '{2, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0};
        vt[8]  = '{2, 2'b11, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0};
        vt[9]  = '{2, 2'b10, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0};
        vt[10] = '{2, 2'b00, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0};
        vt[11] = '{0, 2'b11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        vt[12] = '{3, 2'b00, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_sum", rsp_sum, 32'd0);
        chk("rst_cout", 32'(rsp_cout), 32'd0);
        chk("rst_ovf", 32'(rsp_ovf), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_add_cin", 32'(add_cin), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int v = 0; v < 13; v++) begin
            do_req(vt[v].id, vt[v].op, vt[v].a, vt[v].b);
            @(negedge clk);
            chk("vec_valid", 32'(rsp_valid), 32'd1);
            chk("vec_id", 32'(rsp_id), 32'(vt[v].id));
            chk("vec_sum", rsp_sum, vt[v].sum);
            chk("vec_cout", 32'(rsp_cout), 32'(vt[v].cout));
            chk("vec_ovf", 32'(rsp_ovf), 32'(vt[v].ovf));
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 2'b00, 32'(i * 100 + 1), 32'(i));
        end
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        @(posedge clk);
        #1;

        set_req(2, 2'b10, 32'hFFFFFFFF, 32'h1);
        req_valid = 4'b1101;
        @(negedge clk);
        chk("lock_lo_grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("lock_hold_ready", 32'(req_ready), 32'd0);
            if (k == 0) begin
                chk("lock_lo_id", 32'(rsp_id), 32'd2);
                chk("lock_lo_sum", rsp_sum, 32'h0);
            end
            @(posedge clk);
            #1;
        end
        set_req(2, 2'b11, 32'h0, 32'h0);
        req_valid[2] = 1'b1;
        @(negedge clk);
        chk("lock_hi_grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("lock_next_rr", 32'(req_ready), 32'b1000);
        chk("lock_hi_id", 32'(rsp_id), 32'd2);
        chk("lock_hi_sum", rsp_sum, 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;

        set_req(0, 2'b00, 32'd10, 32'd20);
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("bp_first", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        set_req(0, 2'b00, 32'd1, 32'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_sum", rsp_sum, 32'd30);
            chk("bp_id", 32'(rsp_id), 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("bp_new_valid", 32'(rsp_valid), 32'd1);
        chk("bp_new_sum", rsp_sum, 32'd3);
        @(posedge clk);
        #1;

        rsp_ready = 1'b0;
        do_req(1, 2'b10, 32'hFFFFFFFF, 32'h1);
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_sum", rsp_sum, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_req(1, 2'b11, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_hi_valid", 32'(rsp_valid), 32'd1);
        chk("rst_hi_id", 32'(rsp_id), 32'd1);
        chk("rst_hi_sum", rsp_sum, 32'd0);
        chk("rst_hi_cout", 32'(rsp_cout), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
